// File: rtl/mac_accumulator.sv
// mac_accumulator: sums SETS unsigned products into one dot product. It takes
// products under a valid/ready handshake and holds the result under backpressure.
module mac_accumulator #(
  parameter int unsigned SIZE = 4,
  parameter int unsigned SETS = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*SIZE-1:0]      prod,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*SIZE+SETS-1:0] out,
  output logic [7:0]             count
);

  localparam int unsigned AccW    = 2 * SIZE + SETS;
  localparam logic [7:0]  LastCnt = 8'(SETS - 1);
  localparam logic        OneSet  = (SETS == 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [AccW-1:0] r_acc, w_acc_next;
  logic [7:0]      r_count, w_count_next;
  logic [AccW-1:0] w_prod_ext;

  assign w_prod_ext = {{SETS{1'b0}}, prod};

  // State, accumulator and element counter; reset drops any partial sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
    end
  end

  // Next-state, accumulate and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_acc_next   = w_prod_ext;
          w_count_next = 8'd1;
          w_state_next = OneSet ? StDone : StAccum;
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_acc_next   = r_acc + w_prod_ext;
          w_count_next = r_count + 8'd1;
          if (r_count == LastCnt) w_state_next = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        // Accepting during the output transfer keeps back-to-back sets bubble-free.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_acc_next   = w_prod_ext;
            w_count_next = 8'd1;
            w_state_next = OneSet ? StDone : StAccum;
          end else begin
            w_acc_next   = '0;
            w_count_next = '0;
            w_state_next = StIdle;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_acc_next   = '0;
        w_count_next = '0;
      end
    endcase
  end

  assign out   = r_acc;
  assign count = r_count;

endmodule
